turn_sequencer: RTL

//   Game controller for the 3x3 board. Owns the X (human) and O (AI) mark registers and alternates turns.
//   On the AI's turn it raises ai_turn and waits for the one-hot move from the ai block.

---
 rtl/turn_sequencer_if.sv | 28 ++
 rtl/turn_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/turn_sequencer_if.sv
// Turn sequencer bus: game strobes and moves in, boards and status out.
// master drives moves/strobes; slave (turn_sequencer) drives the board state.
interface turn_sequencer_if;
  logic       new_game;
  logic       human_valid;
  logic [8:0] human_move;
  logic [8:0] ai_move;
  logic       ai_turn;
  logic [8:0] x_board;
  logic [8:0] o_board;
  logic [8:0] occupied;
  logic       game_over;
  logic [1:0] winner;
  logic       illegal;
  logic       ai_fault;

  modport master (
    output new_game, human_valid, human_move, ai_move,
    input  ai_turn, x_board, o_board, occupied,
    input  game_over, winner, illegal, ai_fault
  );

  modport slave (
    input  new_game, human_valid, human_move, ai_move,
    output ai_turn, x_board, o_board, occupied,
    output game_over, winner, illegal, ai_fault
  );
endinterface

// File: rtl/turn_sequencer.sv
// 3x3 game controller: owns X/O boards, alternates turns, judges win/draw.
// Ports: clk, reset (async active-low), bus (turn_sequencer_if.slave).
module turn_sequencer #(
  parameter bit          HUMAN_FIRST = 1'b1,
  parameter int unsigned AI_TIMEOUT  = 15
) (
  input  logic             clk,
  input  logic             reset,
  turn_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {
    HUMAN_WAIT, AI_WAIT, CHECK, DONE
  } state_t;

  localparam state_t START =
    HUMAN_FIRST ? HUMAN_WAIT : AI_WAIT;
  localparam logic [7:0] TMO = 8'(AI_TIMEOUT);

  state_t     state, nxt;
  logic [8:0] x_q, o_q, x_d, o_d;
  logic       mover_q, mover_d;
  logic       settle_q, settle_d;
  logic [7:0] cnt_q, cnt_d;
  logic       turn_q, turn_d;
  logic       over_q, over_d;
  logic       ill_q, ill_d;
  logic       flt_q, flt_d;
  logic [1:0] win_q, win_d;

  logic [8:0] occ, mb;
  logic       h_ok, a_live, a_ok, a_bad;
  logic       won, full;

  function automatic logic legal(
    input logic [8:0] m,
    input logic [8:0] o
  );
    return (m != '0) &&
           ((m & (m - 9'd1)) == '0) &&
           ((m & o) == '0);
  endfunction

  function automatic logic line(
    input logic [8:0] b
  );
    return (&b[8:6]) | (&b[5:3]) | (&b[2:0]) |
           (b[8] & b[5] & b[2]) |
           (b[7] & b[4] & b[1]) |
           (b[6] & b[3] & b[0]) |
           (b[8] & b[4] & b[0]) |
           (b[6] & b[4] & b[2]);
  endfunction

  assign occ  = x_q | o_q;
  assign mb   = mover_q ? o_q : x_q;
  assign won  = line(mb);
  assign full = &occ;
  assign h_ok = bus.human_valid &&
                legal(bus.human_move, occ);
  // first AI_WAIT cycle is a settle cycle
  assign a_live = (state == AI_WAIT) && !settle_q;
  assign a_ok   = a_live && legal(bus.ai_move, occ);
  assign a_bad  = a_live && !a_ok &&
                  (bus.ai_move != '0 || cnt_q == TMO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= START;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (bus.new_game) nxt = START;
    else begin
      unique case (state)
        HUMAN_WAIT: if (h_ok) nxt = CHECK;
        AI_WAIT: begin
          if (a_ok)       nxt = CHECK;
          else if (a_bad) nxt = DONE;
        end
        CHECK: begin
          if (won || full) nxt = DONE;
          else if (mover_q) nxt = HUMAN_WAIT;
          else              nxt = AI_WAIT;
        end
        default: nxt = DONE;
      endcase
    end
  end

  always_comb begin
    x_d     = x_q;
    o_d     = o_q;
    mover_d = mover_q;
    win_d   = win_q;
    flt_d   = flt_q;
    ill_d   = 1'b0;
    cnt_d   = cnt_q;
    if (bus.new_game) begin
      x_d   = '0;
      o_d   = '0;
      win_d = 2'b00;
      cnt_d = '0;
    end else begin
      unique case (state)
        HUMAN_WAIT: begin
          if (h_ok) begin
            x_d     = x_q | bus.human_move;
            mover_d = 1'b0;
          end else if (bus.human_valid) begin
            ill_d = 1'b1;
          end
        end
        AI_WAIT: begin
          if (a_ok) begin
            o_d     = o_q | bus.ai_move;
            mover_d = 1'b1;
          end else if (a_bad) begin
            flt_d = 1'b1;
            win_d = 2'b01;
          end else if (a_live) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        CHECK: begin
          if (won)
            win_d = mover_q ? 2'b10 : 2'b01;
          else if (full)
            win_d = 2'b11;
        end
        default: ;
      endcase
    end
    settle_d = (nxt == AI_WAIT) &&
               (state != AI_WAIT || bus.new_game);
    if (settle_d) cnt_d = '0;
    turn_d = (nxt == AI_WAIT);
    over_d = (nxt == DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q      <= '0;
      o_q      <= '0;
      mover_q  <= 1'b0;
      settle_q <= !HUMAN_FIRST;
      cnt_q    <= '0;
      turn_q   <= 1'b0;
      over_q   <= 1'b0;
      ill_q    <= 1'b0;
      flt_q    <= 1'b0;
      win_q    <= 2'b00;
    end else begin
      x_q      <= x_d;
      o_q      <= o_d;
      mover_q  <= mover_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      turn_q   <= turn_d;
      over_q   <= over_d;
      ill_q    <= ill_d;
      flt_q    <= flt_d;
      win_q    <= win_d;
    end
  end

  assign bus.x_board   = x_q;
  assign bus.o_board   = o_q;
  assign bus.occupied  = occ;
  assign bus.ai_turn   = turn_q;
  assign bus.game_over = over_q;
  assign bus.winner    = win_q;
  assign bus.illegal   = ill_q;
  assign bus.ai_fault  = flt_q;

endmodule
